wb_single_master: RTL and testbench

//  Wishbone initiator that converts one valid/ready command into one classic

---
 rtl/wb_single_master.sv | 199 +++++++++++++++++++
 tb/tb_wb_single_master.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_single_master.sv
// Wishbone single-cycle initiator: one valid/ready command becomes one classic read or write
// cycle with bounded rty retry. Optional bus-wait timeout enabled by `define WB_MASTER_TIMEOUT_EN.
module wb_single_master #(
    parameter int Dw             = 32,
    parameter int Aw             = 32,
    parameter int SELw           = 4,
    parameter int TAGw           = 3,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [Aw-1:0]   cmd_addr,
    input  logic [Dw-1:0]   cmd_dat,
    input  logic [SELw-1:0] cmd_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [Dw-1:0]   rsp_dat,
    output logic [1:0]      rsp_status,
    output logic            m_cyc_o,
    output logic            m_stb_o,
    output logic            m_we_o,
    output logic [Aw-1:0]   m_addr_o,
    output logic [Dw-1:0]   m_dat_o,
    output logic [SELw-1:0] m_sel_o,
    output logic [TAGw-1:0] m_tag_o,
    input  logic [Dw-1:0]   m_dat_i,
    input  logic            m_ack_i,
    input  logic            m_err_i,
    input  logic            m_rty_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RTY_GAP,
        ST_RESP
    } state_t;

    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_ERR     = 2'b01;
    localparam logic [1:0] STAT_RTY_EXH = 2'b10;
    localparam logic [7:0] MAX_RETRY_C  = MAX_RETRY[7:0];

    state_t            state, state_n;
    logic              cmd_ready_n;
    logic              rsp_valid_n;
    logic [Dw-1:0]     rsp_dat_n;
    logic [1:0]        rsp_status_n;
    logic              cyc_n, stb_n, we_n;
    logic [Aw-1:0]     addr_n;
    logic [Dw-1:0]     dat_n;
    logic [SELw-1:0]   sel_n;
    logic [7:0]        retry_cnt, retry_cnt_n;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [1:0] STAT_TIMEOUT = 2'b11;
    localparam int         TW           = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]     wait_cnt, wait_cnt_n;
`endif

    assign m_tag_o = '0;

    always_comb begin
        state_n      = state;
        rsp_valid_n  = rsp_valid;
        rsp_dat_n    = rsp_dat;
        rsp_status_n = rsp_status;
        cyc_n        = m_cyc_o;
        stb_n        = m_stb_o;
        we_n         = m_we_o;
        addr_n       = m_addr_o;
        dat_n        = m_dat_o;
        sel_n        = m_sel_o;
        retry_cnt_n  = retry_cnt;
`ifdef WB_MASTER_TIMEOUT_EN
        wait_cnt_n   = wait_cnt;
`endif
        unique case (state)
            ST_IDLE: begin
                if (cmd_ready && cmd_valid) begin
                    state_n     = ST_BUS;
                    cyc_n       = 1'b1;
                    stb_n       = 1'b1;
                    we_n        = cmd_we;
                    addr_n      = cmd_addr;
                    dat_n       = cmd_dat;
                    sel_n       = cmd_sel;
                    retry_cnt_n = '0;
`ifdef WB_MASTER_TIMEOUT_EN
                    wait_cnt_n  = '0;
`endif
                end
            end
            ST_BUS: begin
                // Every exit from BUS drops cyc/stb on the response edge itself.
                if (m_ack_i) begin
                    state_n      = ST_RESP;
                    cyc_n        = 1'b0;
                    stb_n        = 1'b0;
                    rsp_dat_n    = m_we_o ? '0 : m_dat_i;
                    rsp_status_n = STAT_OK;
                end else if (m_err_i) begin
                    state_n      = ST_RESP;
                    cyc_n        = 1'b0;
                    stb_n        = 1'b0;
                    rsp_dat_n    = '0;
                    rsp_status_n = STAT_ERR;
                end else if (m_rty_i) begin
                    cyc_n = 1'b0;
                    stb_n = 1'b0;
                    if (retry_cnt < MAX_RETRY_C) begin
                        state_n     = ST_RTY_GAP;
                        retry_cnt_n = retry_cnt + 8'd1;
                    end else begin
                        state_n      = ST_RESP;
                        rsp_dat_n    = '0;
                        rsp_status_n = STAT_RTY_EXH;
                    end
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (wait_cnt == WAIT_LAST) begin
                    state_n      = ST_RESP;
                    cyc_n        = 1'b0;
                    stb_n        = 1'b0;
                    rsp_dat_n    = '0;
                    rsp_status_n = STAT_TIMEOUT;
                end else begin
                    wait_cnt_n = wait_cnt + TW'(1);
                end
`endif
            end
            ST_RTY_GAP: begin
                state_n = ST_BUS;
                cyc_n   = 1'b1;
                stb_n   = 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
                wait_cnt_n = '0;
`endif
            end
            ST_RESP: begin
                // First RESP cycle raises rsp_valid; the handshake edge returns to IDLE.
                if (!rsp_valid) begin
                    rsp_valid_n = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        cmd_ready_n = (state_n == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_dat    <= '0;
            rsp_status <= '0;
            m_cyc_o    <= 1'b0;
            m_stb_o    <= 1'b0;
            m_we_o     <= 1'b0;
            m_addr_o   <= '0;
            m_dat_o    <= '0;
            m_sel_o    <= '0;
            retry_cnt  <= '0;
        end else begin
            state      <= state_n;
            cmd_ready  <= cmd_ready_n;
            rsp_valid  <= rsp_valid_n;
            rsp_dat    <= rsp_dat_n;
            rsp_status <= rsp_status_n;
            m_cyc_o    <= cyc_n;
            m_stb_o    <= stb_n;
            m_we_o     <= we_n;
            m_addr_o   <= addr_n;
            m_dat_o    <= dat_n;
            m_sel_o    <= sel_n;
            retry_cnt  <= retry_cnt_n;
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_n;
        end
    end
`endif

endmodule

// File: tb/tb_wb_single_master.sv
// Directed bench for wb_single_master; timeout scenario built only with WB_MASTER_TIMEOUT_EN.
module tb_wb_single_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [31:0] m_addr_o, m_dat_o, m_dat_i;
    logic [3:0]  m_sel_o;
    logic [2:0]  m_tag_o;
    logic        m_ack_i, m_err_i, m_rty_i;

    int compared   = 0;
    int mismatched = 0;

    wb_single_master #(
        .Dw(32), .Aw(32), .SELw(4), .TAGw(3),
        .MAX_RETRY(3), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dat(rsp_dat), .rsp_status(rsp_status),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_addr_o(m_addr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
        .m_tag_o(m_tag_o), .m_dat_i(m_dat_i),
        .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i)
    );

    always #5 clk = ~clk;

    // Presents one command at a negedge and returns at the negedge after acceptance.
    task automatic issue_cmd(input logic we, input logic [31:0] addr,
                             input logic [31:0] dat, input logic [3:0] sel);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL issue_cmd: cmd_ready got 0 required 1 within 20 cycles");
        end
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_dat = dat; cmd_sel = sel;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic consume;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Zero-wait slave: rty for the first n_rty strobes, then ack (or rty forever).
    task automatic run_slave(input int n_rty, input bit final_ack,
                             output int strobes, output int gaps);
        int pend = 0;
        strobes = 0; gaps = 0;
        for (int c = 0; c < 60 && !rsp_valid; c++) begin
            if (m_stb_o) begin
                strobes++; gaps += pend; pend = 0;
                if (strobes <= n_rty || !final_ack) m_rty_i = 1'b1;
                else m_ack_i = 1'b1;
            end else if (strobes > 0 && m_cyc_o == 1'b0) begin
                pend++;
            end
            @(negedge clk);
            m_ack_i = 1'b0; m_rty_i = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 0; m_dat_i = '0; m_ack_i = 0; m_err_i = 0; m_rty_i = 0;
        #12;
        compared++;
        if ({cmd_ready, rsp_valid, rsp_dat, rsp_status, m_cyc_o, m_stb_o, m_we_o,
             m_addr_o, m_dat_o, m_sel_o, m_tag_o} !== 112'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: some output nonzero during reset (cmd_ready=%b cyc=%b stb=%b)",
                     cmd_ready, m_cyc_o, m_stb_o);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        compared++;
        if (cmd_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release_ready: got %b required 0", cmd_ready);
        end
        @(negedge clk);
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL first_edge_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_zero_wait_write;
        bit ok;
        issue_cmd(1'b1, 32'h1, 32'h5, 4'hF);
        compared++;
        if ({m_cyc_o, m_stb_o, m_we_o, m_addr_o, m_dat_o, m_sel_o, cmd_ready} !==
            {1'b1, 1'b1, 1'b1, 32'h1, 32'h5, 4'hF, 1'b0}) begin
            mismatched++;
            $display("FAIL write_bus: cyc=%b stb=%b we=%b addr=%0h dat=%0h sel=%0h required 1 1 1 1 5 f",
                     m_cyc_o, m_stb_o, m_we_o, m_addr_o, m_dat_o, m_sel_o);
        end
        m_ack_i = 1'b1; m_dat_i = 32'hDEAD;
        @(negedge clk);
        m_ack_i = 1'b0; m_dat_i = '0;
        compared++;
        if ({m_cyc_o, m_stb_o, rsp_valid} !== 3'b000) begin
            mismatched++;
            $display("FAIL write_drop: cyc/stb/rsp_valid got %b%b%b required 000",
                     m_cyc_o, m_stb_o, rsp_valid);
        end
        @(negedge clk);
        compared++;
        if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'b00, 32'h0}) begin
            mismatched++;
            $display("FAIL write_rsp_latency: valid=%b status=%b dat=%0h required 1 00 0",
                     rsp_valid, rsp_status, rsp_dat);
        end
        consume();
        compared++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            mismatched++;
            $display("FAIL write_consume: valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_wait_read;
        bit ok;
        int stb_cnt = 0;
        issue_cmd(1'b0, 32'h20, 32'h0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            if (m_stb_o) stb_cnt++;
            if (i == 4) begin m_ack_i = 1'b1; m_dat_i = 32'hA5; end
            @(negedge clk);
        end
        m_ack_i = 1'b0; m_dat_i = '0;
        compared++;
        if ({stb_cnt == 5, m_cyc_o, m_stb_o} !== 3'b100) begin
            mismatched++;
            $display("FAIL wait_read_strobe: stb cycles %0d cyc=%b stb=%b required 5 0 0",
                     stb_cnt, m_cyc_o, m_stb_o);
        end
        wait_rsp(ok);
        compared++;
        if (!ok || rsp_dat !== 32'hA5 || rsp_status !== 2'b00) begin
            mismatched++;
            $display("FAIL wait_read_rsp: valid=%b dat=%0h status=%b required 1 a5 00",
                     rsp_valid, rsp_dat, rsp_status);
        end
        consume();
    endtask

    task automatic test_retry;
        bit ok;
        int strobes, gaps;
        m_dat_i = 32'h1234;
        issue_cmd(1'b0, 32'h44, 32'h0, 4'h3);
        run_slave(2, 1'b1, strobes, gaps);
        wait_rsp(ok);
        compared++;
        if (!ok || strobes != 3 || gaps != 2 || rsp_status !== 2'b00 || rsp_dat !== 32'h1234) begin
            mismatched++;
            $display("FAIL retry_then_ack: strobes=%0d gaps=%0d status=%b dat=%0h required 3 2 00 1234",
                     strobes, gaps, rsp_status, rsp_dat);
        end
        consume();
        issue_cmd(1'b0, 32'h48, 32'h0, 4'h3);
        run_slave(4, 1'b0, strobes, gaps);
        wait_rsp(ok);
        m_dat_i = '0;
        compared++;
        if (!ok || strobes != 4 || gaps != 3 || rsp_status !== 2'b10 || rsp_dat !== 32'h0) begin
            mismatched++;
            $display("FAIL retry_exhausted: strobes=%0d gaps=%0d status=%b dat=%0h required 4 3 10 0",
                     strobes, gaps, rsp_status, rsp_dat);
        end
        consume();
    endtask

    task automatic test_err;
        bit ok;
        issue_cmd(1'b0, 32'h50, 32'h0, 4'hF);
        m_ack_i = 1'b1; m_err_i = 1'b1; m_dat_i = 32'h33;
        @(negedge clk);
        m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = '0;
        wait_rsp(ok);
        compared++;
        if (!ok || rsp_status !== 2'b00 || rsp_dat !== 32'h33) begin
            mismatched++;
            $display("FAIL ack_over_err: status=%b dat=%0h required 00 33", rsp_status, rsp_dat);
        end
        consume();
        issue_cmd(1'b0, 32'h54, 32'h0, 4'hF);
        m_err_i = 1'b1; m_dat_i = 32'h77;
        @(negedge clk);
        m_err_i = 1'b0; m_dat_i = '0;
        wait_rsp(ok);
        compared++;
        if (!ok || rsp_status !== 2'b01 || rsp_dat !== 32'h0) begin
            mismatched++;
            $display("FAIL err_alone: status=%b dat=%0h required 01 0", rsp_status, rsp_dat);
        end
        consume();
    endtask

    task automatic test_backpressure;
        bit ok;
        issue_cmd(1'b0, 32'h60, 32'h0, 4'hF);
        m_ack_i = 1'b1; m_dat_i = 32'h5A;
        @(negedge clk);
        m_ack_i = 1'b0; m_dat_i = '0;
        wait_rsp(ok);
        for (int i = 0; i < 10; i++) begin
            compared++;
            if ({rsp_valid, rsp_dat, rsp_status, cmd_ready} !== {1'b1, 32'h5A, 2'b00, 1'b0}) begin
                mismatched++;
                $display("FAIL hold_rsp[%0d]: valid=%b dat=%0h status=%b cmd_ready=%b required 1 5a 00 0",
                         i, rsp_valid, rsp_dat, rsp_status, cmd_ready);
            end
            @(negedge clk);
        end
        consume();
        compared++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            mismatched++;
            $display("FAIL release_rsp: valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_back_to_back;
        int acc[8];
        int n_acc = 0, n_rsp = 0;
        bit spacing_ok = 1;
        rsp_ready = 1'b1;
        cmd_we = 1'b1; cmd_addr = 32'h70; cmd_dat = 32'h9; cmd_sel = 4'hF;
        for (int i = 0; i < 20; i++) begin
            cmd_valid = (i <= 16);
            if (cmd_valid && cmd_ready && n_acc < 8) begin acc[n_acc] = i; n_acc++; end
            if (rsp_valid) n_rsp++;
            m_ack_i = m_stb_o;
            @(negedge clk);
        end
        cmd_valid = 1'b0; m_ack_i = 1'b0; rsp_ready = 1'b0;
        for (int k = 1; k < n_acc; k++)
            if (acc[k] - acc[k-1] != 4) spacing_ok = 0;
        compared++;
        if (n_acc != 5 || n_rsp != 5 || !spacing_ok) begin
            mismatched++;
            $display("FAIL back_to_back: accepts=%0d responses=%0d spacing_ok=%0d required 5 5 1",
                     n_acc, n_rsp, spacing_ok);
        end
    endtask

    task automatic test_reset_mid_bus;
        int seen = 0;
        issue_cmd(1'b0, 32'h80, 32'h0, 4'hF);
        #3 reset = 1'b1;
        #1;
        compared++;
        if ({m_cyc_o, m_stb_o, rsp_valid} !== 3'b000) begin
            mismatched++;
            $display("FAIL async_reset_drop: cyc/stb/rsp_valid got %b%b%b required 000",
                     m_cyc_o, m_stb_o, rsp_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        m_ack_i = 1'b1; m_err_i = 1'b1; m_rty_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid || m_cyc_o) seen++;
        end
        m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0;
        compared++;
        if (seen != 0 || cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL idle_ignores_bus: busy cycles=%0d cmd_ready=%b required 0 1", seen, cmd_ready);
        end
    endtask

`ifdef WB_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        int strobes = 0;
        issue_cmd(1'b0, 32'h90, 32'h0, 4'hF);
        for (int c = 0; c < 40 && !rsp_valid; c++) begin
            if (m_stb_o) strobes++;
            @(negedge clk);
        end
        wait_rsp(ok);
        compared++;
        if (!ok || strobes != 8 || rsp_status !== 2'b11 || rsp_dat !== 32'h0) begin
            mismatched++;
            $display("FAIL timeout: strobes=%0d status=%b dat=%0h required 8 11 0",
                     strobes, rsp_status, rsp_dat);
        end
        consume();
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_retry();
        test_err();
        test_backpressure();
        test_back_to_back();
`ifdef WB_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_bus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
